multi_freq_divider: RTL and testbench

//  Multi-channel programmable divider for the 27 MHz system clock. Each of NUM_CH channels

---
 rtl/multi_freq_divider.sv | 117 +++++++++++
 tb/tb_multi_freq_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multi_freq_divider.sv
// NUM_CH independent programmable tick dividers whose divisors can be rewritten glitch-free at run time.
// Define FREQ_DIV_SQUARE_EN to build the per-channel slow_clk toggle flops; otherwise slow_clk is tied low.
module multi_freq_divider #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 13500,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] div_pend
);

    localparam logic [CNT_W-1:0] RST_DIV = (DEF_DIV < 2) ? CNT_W'(1) : CNT_W'(DEF_DIV);

    // A divisor of 0 would leave the counter without a terminal count, so it is stored as 1.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(1) : v;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             wr_hit, at_tc;

        assign wr_hit = div_wr && (div_sel == SEL_W'(c));
        assign at_tc  = (cnt_q == act_q - CNT_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            if (!ch_en[c]) begin
                // No period is running, so any new divisor can be taken over at once.
                cnt_d  = '0;
                pend_d = 1'b0;
                if (wr_hit) begin
                    act_d = clamp_div(div_val);
                    shd_d = clamp_div(div_val);
                end else if (pend_q) begin
                    act_d = shd_q;
                end
            end else if (at_tc) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                pend_d = 1'b0;
                if (wr_hit) begin
                    act_d = clamp_div(div_val);
                end else if (pend_q) begin
                    act_d = shd_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wr_hit) begin
                    shd_d  = clamp_div(div_val);
                    pend_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                act_q  <= RST_DIV;
                shd_q  <= RST_DIV;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
            end
        end

        assign tick[c]     = tick_q;
        assign div_pend[c] = pend_q;

`ifdef FREQ_DIV_SQUARE_EN
        logic sq_q, sq_d;

        always_comb begin
            sq_d = sq_q;
            if (!ch_en[c]) begin
                sq_d = 1'b0;
            end else if (at_tc) begin
                sq_d = ~sq_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sq_d;
            end
        end

        assign slow_clk[c] = sq_q;
`else
        assign slow_clk[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_freq_divider.sv
// Directed bench for multi_freq_divider (DEF_DIV=5, NUM_CH=4) plus a 3-channel instance for out-of-range selects.
module tb_multi_freq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [15:0] div_val;
    logic [3:0]  tick;
    logic [3:0]  slow_clk;
    logic [3:0]  div_pend;

    logic [2:0]  ch_en3;
    logic        div_wr3;
    logic [1:0]  div_sel3;
    logic [15:0] div_val3;
    logic [2:0]  tick3;
    logic [2:0]  slow3;
    logic [2:0]  div_pend3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_freq_divider #(.NUM_CH(4), .CNT_W(16), .DEF_DIV(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .div_wr(div_wr), .div_sel(div_sel),
        .div_val(div_val), .tick(tick), .slow_clk(slow_clk), .div_pend(div_pend)
    );

    multi_freq_divider #(.NUM_CH(3), .CNT_W(16), .DEF_DIV(5)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en3), .div_wr(div_wr3), .div_sel(div_sel3),
        .div_val(div_val3), .tick(tick3), .slow_clk(slow3), .div_pend(div_pend3)
    );

    // Expected slow_clk: the toggle pattern when square outputs are built, otherwise constant 0.
    function automatic logic [3:0] sq4(input logic [3:0] v);
`ifdef FREQ_DIV_SQUARE_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; ch_en = 4'h0; div_wr = 1'b0; div_sel = 2'd0; div_val = 16'd0;
        ch_en3 = 3'h0; div_wr3 = 1'b0; div_sel3 = 2'd0; div_val3 = 16'd0;
        step(2);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_slow", 32'(slow_clk), 32'h0);
        chk("rst_pend", 32'(div_pend), 32'h0);

        // Edges are numbered from release; all channels tick on multiples of 5.
        rst_n = 1'b1; ch_en = 4'hF; ch_en3 = 3'h7;
        step(4);
        chk("t1_tick_e4", 32'(tick), 32'h0);
        step(1);
        chk("t1_tick_e5", 32'(tick), 32'hF);
        chk("t1_slow_e5", 32'(slow_clk), 32'(sq4(4'hF)));
        step(1);
        chk("t1_tick_e6", 32'(tick), 32'h0);
        step(4);
        chk("t1_tick_e10", 32'(tick), 32'hF);
        chk("t1_slow_e10", 32'(slow_clk), 32'(sq4(4'h0)));

        // Ch1 rewritten at cnt=1; the 3-channel instance gets a write to nonexistent channel 3.
        step(1);
        div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd3;
        div_wr3 = 1'b1; div_sel3 = 2'd3; div_val3 = 16'd2;
        step(1);
        div_wr = 1'b0; div_wr3 = 1'b0;
        chk("t2_pend_e12", 32'(div_pend), 32'h2);
        chk("oor_pend_e12", 32'(div_pend3), 32'h0);
        chk("t2_tick_e12", 32'(tick), 32'h0);
        step(2);
        chk("t2_pend_e14", 32'(div_pend), 32'h2);
        chk("t2_tick_e14", 32'(tick), 32'h0);
        step(1);
        chk("t2_tick_e15", 32'(tick), 32'hF);
        chk("t2_pend_e15", 32'(div_pend), 32'h0);
        step(3);
        chk("t2_tick_e18", 32'(tick), 32'h2);
        step(2);
        chk("t2_tick_e20", 32'(tick), 32'hD);
        chk("oor_tick_e20", 32'(tick3), 32'h7);
        step(1);
        chk("t2_tick_e21", 32'(tick), 32'h2);
        chk("t2_slow_e21", 32'(slow_clk), 32'(sq4(4'h2)));

        // Ch2 gets 0 then 1: both clamp to 1, applied at its boundary on edge 25.
        div_wr = 1'b1; div_sel = 2'd2; div_val = 16'd0;
        step(1);
        div_val = 16'd1;
        step(1);
        div_wr = 1'b0;
        chk("t3_pend_e23", 32'(div_pend), 32'h4);
        step(2);
        chk("t3_tick_e25", 32'(tick), 32'hD);
        chk("t3_pend_e25", 32'(div_pend), 32'h0);
        chk("t3_slow_e25", 32'(slow_clk), 32'(sq4(4'hD)));
        step(1);
        chk("t3_tick_e26", 32'(tick), 32'h4);
        chk("t3_slow_e26", 32'(slow_clk), 32'(sq4(4'h9)));
        step(1);
        chk("t3_tick_e27", 32'(tick), 32'h6);
        chk("t3_slow_e27", 32'(slow_clk), 32'(sq4(4'hF)));

        // Ch3 written with 7 on its terminal-count edge 30: no pending, next tick at 37.
        step(2);
        div_wr = 1'b1; div_sel = 2'd3; div_val = 16'd7;
        step(1);
        div_wr = 1'b0;
        chk("t4_pend_e30", 32'(div_pend), 32'h0);
        chk("t4_tick_e30", 32'(tick), 32'hF);
        step(6);
        chk("t4_tick_e36", 32'(tick), 32'h6);
        step(1);
        chk("t4_tick_e37", 32'(tick), 32'hC);

        // Ch0 disabled mid-count, reprogrammed to 2 while idle, then re-enabled.
        ch_en = 4'hE;
        step(1);
        chk("t5_tick_e38", 32'(tick), 32'h4);
        chk("t5_slow_e38", 32'(slow_clk), 32'(sq4(4'h8)));
        div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd2;
        step(1);
        div_wr = 1'b0;
        chk("t5_pend_e39", 32'(div_pend), 32'h0);
        chk("t5_tick_e39", 32'(tick), 32'h6);
        ch_en = 4'hF;
        step(1);
        chk("t5_tick_e40", 32'(tick), 32'h4);
        step(1);
        chk("t5_tick_e41", 32'(tick), 32'h5);
        chk("t5_slow0_e41", 32'(slow_clk & 4'h1), 32'(sq4(4'h1)));

        // Pending write to ch3, then asynchronous reset mid-count.
        div_wr = 1'b1; div_sel = 2'd3; div_val = 16'd9;
        step(1);
        div_wr = 1'b0;
        chk("t6_pend_e42", 32'(div_pend), 32'h8);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_tick", 32'(tick), 32'h0);
        chk("t6_rst_slow", 32'(slow_clk), 32'h0);
        chk("t6_rst_pend", 32'(div_pend), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("t6_tick_r4", 32'(tick), 32'h0);
        step(1);
        chk("t6_tick_r5", 32'(tick), 32'hF);
        chk("t6_slow_r5", 32'(slow_clk), 32'(sq4(4'hF)));
        chk("t6_pend_r5", 32'(div_pend), 32'h0);
        step(5);
        chk("t6_tick_r10", 32'(tick), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
